// File: rtl/min_rank_pkg.sv
// Shared types, sizes and slot helper for the min-rank sequencer.
// Optional abort support is enabled by defining MIN_RANK_ABORT_EN.
package min_rank_pkg;

    localparam int N_VALS = 8;
    localparam int VAL_W  = 12;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        EMIT
    } state_t;

    function automatic logic [VAL_W-1:0] get_slot(
        input logic [N_VALS*VAL_W-1:0] v,
        input int                      k
    );
        return v[k*VAL_W +: VAL_W];
    endfunction

endpackage

// File: rtl/min_rank_sequencer_if.sv
// Frame input, result handshake and status bundle of the sequencer.
// abort_in exists only when MIN_RANK_ABORT_EN is defined.
interface min_rank_sequencer_if;
    import min_rank_pkg::*;

    logic [N_VALS*VAL_W-1:0] vals_in;
    logic [3:0]              count_in;
    logic                    start_in;
    logic                    busy_out;
    logic                    valid_out;
    logic                    ready_in;
    logic [IDX_W-1:0]        idx_out;
    logic [VAL_W-1:0]        val_out;
    logic                    last_out;
    logic                    done_out;
`ifdef MIN_RANK_ABORT_EN
    logic                    abort_in;

    modport master (
        output vals_in, count_in, start_in, ready_in, abort_in,
        input  busy_out, valid_out, idx_out, val_out, last_out,
        input  done_out
    );

    modport slave (
        input  vals_in, count_in, start_in, ready_in, abort_in,
        output busy_out, valid_out, idx_out, val_out, last_out,
        output done_out
    );
`else
    modport master (
        output vals_in, count_in, start_in, ready_in,
        input  busy_out, valid_out, idx_out, val_out, last_out,
        input  done_out
    );

    modport slave (
        input  vals_in, count_in, start_in, ready_in,
        output busy_out, valid_out, idx_out, val_out, last_out,
        output done_out
    );
`endif

endinterface

// File: rtl/min_rank_sequencer_masked_argmin.sv
// Combinational argmin over the unmasked slots; lowest index wins ties.
module masked_argmin
    import min_rank_pkg::*;
(
    input  logic [N_VALS*VAL_W-1:0] vals_i,
    input  logic [N_VALS-1:0]       mask_i,
    output logic [IDX_W-1:0]        idx_o
);

    logic [VAL_W-1:0] best_val;
    logic             found;

    // Strict < keeps the earliest index among equal values.
    always_comb begin
        idx_o    = '0;
        best_val = '1;
        found    = 1'b0;
        for (int k = 0; k < N_VALS; k++) begin
            if (mask_i[k] &&
                (!found || get_slot(vals_i, k) < best_val)) begin
                idx_o    = IDX_W'(k);
                best_val = get_slot(vals_i, k);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/min_rank_sequencer.sv
// Emits a captured frame's slot indices in ascending value order.
// Define MIN_RANK_ABORT_EN to add the abort_in frame-cancel input.
module min_rank_sequencer
    import min_rank_pkg::*;
(
    input logic                 clk_in,
    input logic                 rst_in,
    min_rank_sequencer_if.slave bus
);

    state_t                  state_q, state_d;
    logic [N_VALS*VAL_W-1:0] vals_q, vals_d;
    logic [N_VALS-1:0]       mask_q, mask_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [VAL_W-1:0]        val_q, val_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;

    logic [3:0]              cnt;
    logic [N_VALS-1:0]       start_mask;
    logic [IDX_W-1:0]        min_idx;

    masked_argmin u_argmin (
        .vals_i (vals_q),
        .mask_i (mask_q),
        .idx_o  (min_idx)
    );

    always_comb begin
        cnt = (bus.count_in > 4'(N_VALS)) ? 4'(N_VALS)
                                          : bus.count_in;
        start_mask = '0;
        for (int k = 0; k < N_VALS; k++) begin
            start_mask[k] = (4'(k) < cnt);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            vals_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vals_q  <= vals_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vals_d  = vals_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        val_d   = val_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    vals_d = bus.vals_in;
                    mask_d = start_mask;
                    if (start_mask == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                idx_d   = min_idx;
                val_d   = get_slot(vals_q, int'(min_idx));
                last_d  = ($countones(mask_q) == 1);
                state_d = EMIT;
            end
            EMIT: begin
                if (bus.ready_in) begin
                    mask_d[idx_q] = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MIN_RANK_ABORT_EN
        // Abort overrides any handshake landing on the same edge.
        if (bus.abort_in && state_q != IDLE) begin
            state_d = IDLE;
            mask_d  = '0;
            done_d  = 1'b1;
        end
`endif
    end

    assign bus.busy_out  = (state_q != IDLE);
    assign bus.valid_out = (state_q == EMIT);
    assign bus.idx_out   = idx_q;
    assign bus.val_out   = val_q;
    assign bus.last_out  = last_q && (state_q == EMIT);
    assign bus.done_out  = done_q;

endmodule

// File: doc/min_rank_sequencer.md
Name: min_rank_sequencer

Overview:
- Sequences a masked argmin search over a captured frame of up to 8 12-bit values.
- Emits the value indices one per handshake, in ascending value order: repeated argmin, masking out each emitted entry.
- Feeds downstream consumers (ball/hand assignment) that need a full ranking rather than a single minimum.
- Sits between the frame-producing logic and the assignment/scheduling stage.

Parameters:
- N_VALS, 8, number of value slots; power of two, at most 8.
- VAL_W, 12, width of each value.
- IDX_W, 3, index width, equal to log2(N_VALS).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous and active-low: the block resets on the clk_in edge where rst_in==0
- vals_in  input  N_VALS*VAL_W  flattened values; slot k occupies bits [k*VAL_W +: VAL_W]
- count_in  input  4  number of active slots, counted from slot 0; values above N_VALS are clamped to N_VALS
- start_in  input  1  single-cycle pulse that captures vals_in and count_in
- busy_out  output  1  high whenever the state is not IDLE
- valid_out  output  1  idx_out/val_out hold a valid result
- ready_in  input  1  consumer accepts the result
- idx_out  output  IDX_W  index of the current minimum
- val_out  output  VAL_W  value of the current minimum
- last_out  output  1  qualifies valid_out; this is the final entry of the frame
- done_out  output  1  single-cycle pulse when the frame is finished

Behaviour:
- Reset (rst_in==0 at a clk_in edge):
  - state goes to IDLE; captured values and the mask are cleared.
  - All outputs are 0.
  - Applies in any state, mid-frame included; the partial frame is discarded and done_out is not pulsed.
- IDLE, start_in==1:
  - Register all slots and set mask[k]=1 for each k < clamped count.
  - If count==0: done_out pulses on the next cycle and the state stays IDLE; no valid_out is ever raised.
  - Otherwise go to SEARCH.
- start_in outside IDLE is ignored and has no effect on the frame in progress.
- SEARCH (one cycle):
  - Combinational masked argmin over the captured values; strict < comparison, so the lowest index wins ties.
  - The result is registered into idx_out and val_out.
  - last_out = (popcount(mask)==1).
  - Go to EMIT.
- EMIT:
  - valid_out=1; idx_out, val_out and last_out are held stable until valid_out&&ready_in.
  - On handshake, clear mask[idx_out] and drop valid_out on the next cycle.
  - If the emitted entry was the last: done_out pulses on the cycle after the handshake and the state goes to IDLE.
  - Otherwise go to SEARCH.
- Timing:
  - Latency from start_in to the first valid_out is 2 cycles.
  - Best-case throughput is 1 result per 2 cycles.
- Stall/reset interaction: ready_in held low stalls indefinitely. Reset while valid_out is high clears it without a handshake.
- Masked-out slots never participate in the search, whatever their value; all-ones values are legal.
- Values are unsigned. No arithmetic beyond comparison.

Optional Feature:
- Macro: MIN_RANK_ABORT_EN.
- Defined:
  - Adds port abort_in (input, 1).
  - abort_in high in SEARCH or EMIT drops valid_out and returns to IDLE on the next cycle, clearing the mask.
  - done_out pulses that same cycle.
  - abort_in takes priority over a simultaneous handshake; the handshake is not counted.
  - abort_in in IDLE is ignored.
- Undefined: no abort_in port; frames always run to completion or reset.

Decomposition:
- Package min_rank_pkg holds:
  - state enum {IDLE, SEARCH, EMIT};
  - constants N_VALS, VAL_W, IDX_W;
  - the slot-extraction helper function.
- Natural sub-module: masked_argmin, combinational.
  - Inputs: N_VALS values plus an N_VALS-bit mask.
  - Output: index of the lowest unmasked value, lowest index winning ties.
- The sequencer instantiates one masked_argmin and holds all registers and state.

Test Plan:
- Values {40,7,300,7,12,999,1,50}, count 8, ready_in tied high -> idx sequence 6,1,3,4,0,7,2,5; last_out only with idx 5; done_out 1 cycle after the final handshake.
- Same values, count 3 -> idx 1,0,2; slots 3-7 are never emitted, despite slot 6 holding the smallest value.
- count 0 -> done_out pulses 1 cycle after start_in; valid_out never rises; busy_out stays 0.
- count 12 -> clamped to 8; exactly 8 results.
- ready_in low for 5 cycles on the first result -> idx_out/val_out/valid_out stable throughout; second start_in while busy ignored; rst_in low mid-frame -> next cycle all outputs 0, state IDLE, no done_out.
- (MIN_RANK_ABORT_EN) abort_in coincident with the second handshake -> valid_out 0 and done_out 1 next cycle; a fresh start_in then gives the full correct sequence.
